// File: rtl/n_adder_pkg.sv
// Shared definitions for the packet accumulator: state encoding, default widths
// and the saturating increment used by the beat and carry counters.
package n_adder_pkg;

  localparam int DEFAULT_N     = 16;
  localparam int DEFAULT_CNT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    HOLD  = ST_HOLD
  } state_t;

  // Adds inc to v, sticking at 2^w-1 instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (inc && (v < max_v)) begin
      return v + 32'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/n_bit_accumulator_adder.sv
// Plain combinational n-bit ripple adder with carry in/out.
// Zero latency; no flow control of its own.
module N_bit_adder #(
  parameter int n = 16
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};

endmodule

// File: rtl/n_bit_accumulator.sv
// Sums a valid/ready operand stream per packet; result valid the cycle after the last beat.
// While a result is held, in_ready drops until out_ready completes the handshake.
module n_bit_accumulator
  import n_adder_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic [CNT_W-1:0] out_count
);

  state_t state, state_nxt;

  logic [N-1:0]     acc, acc_nxt;
  logic [CNT_W-1:0] carries, carries_nxt;
  logic [CNT_W-1:0] count, count_nxt;

  logic [N-1:0]     adder_a;
  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic [CNT_W-1:0] carries_base;
  logic [CNT_W-1:0] count_base;
  logic             accept;

  assign in_ready = !rst && (state != HOLD);
  assign accept   = in_valid && in_ready;

  // A packet's first beat starts from zero regardless of what acc holds.
  assign adder_a      = (state == IDLE) ? '0 : acc;
  assign carries_base = (state == IDLE) ? '0 : carries;
  assign count_base   = (state == IDLE) ? '0 : count;

  N_bit_adder #(
    .n(N)
  ) u_adder (
    .a   (adder_a),
    .b   (in_data),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    carries_nxt = carries;
    count_nxt   = count;

    if (accept) begin
      acc_nxt     = add_sum;
      carries_nxt = CNT_W'(sat_inc(32'(carries_base), add_cout, CNT_W));
      count_nxt   = CNT_W'(sat_inc(32'(count_base), 1'b1, CNT_W));
    end

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && in_last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt   = IDLE;
          acc_nxt     = '0;
          carries_nxt = '0;
          count_nxt   = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        acc_nxt     = '0;
        carries_nxt = '0;
        count_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      carries <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      carries <= carries_nxt;
      count   <= count_nxt;
    end
  end

  // Registers are frozen in HOLD, so the result is presented straight from them.
  assign out_valid   = (state == HOLD);
  assign out_sum     = acc;
  assign out_carries = carries;
  assign out_count   = count;

endmodule
